// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encodings,
// the SYNC byte, error-cause codes and the timeout length helper.
// Checksum support is selected elsewhere by the UART_FRAME_CSUM_EN macro.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  // Inter-byte silence allowed, in clock cycles.
  function automatic int timeout_cycles(input int freq, input int rate, input int bits);
    return (freq / rate) * bits;
  endfunction

endpackage

// File: rtl/uart_frame_rx_timeout.sv
// frame_timeout: counts cycles since the last load while enabled; pulses expire_o after LIMIT cycles.
// Latency: expire_o is combinational from the count, asserted in the LIMIT-th cycle after a load.
// Backpressure: none; load_i restarts the count, deasserting en_i clears it.
module frame_timeout #(
  parameter int LIMIT = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart on a byte or when disabled, otherwise count up and saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SYNC/LEN/payload[/CSUM] byte frames and replays the payload on a valid/ready port.
// Latency: first payload byte is valid the cycle after the final frame byte; errors pulse one cycle after the cause.
// Backpressure: output holds while o_vld && !i_rdy; input has none, bytes arriving during OUT are dropped (overrun).
// Checksum stage present only when UART_FRAME_CSUM_EN is defined.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int FREQ         = 50_000_000,
  parameter int RATE         = 2_000_000,
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_vld,
  output logic [7:0] o_data,
  output logic       o_vld,
  output logic       o_last,
  input  logic       i_rdy,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       buf_we;
  logic       tmo_load, tmo_en, tmo_expire;
  logic       last_idx;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_chk;
`endif

  logic [7:0] buf_q [MAX_LEN];

  frame_timeout #(
    .LIMIT(timeout_cycles(FREQ, RATE, TIMEOUT_BITS))
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmo_load),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );

  assign tmo_en   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign last_idx = (idx_q == len_q - 8'd1);
`ifdef UART_FRAME_CSUM_EN
  assign sum_chk  = sum_q + i_data;
`endif

  // Next-state logic: byte strobes drive every transition except draining OUT; a byte beats a timeout.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    code_d   = code_q;
    buf_we   = 1'b0;
    tmo_load = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_data_vld && (i_data == SYNC_BYTE)) begin
          state_d  = ST_LEN;
          tmo_load = 1'b1;
        end
      end
      ST_LEN: begin
        if (i_data_vld) begin
          tmo_load = 1'b1;
          if ((i_data == 8'd0) || (i_data > MAX_LEN_B)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            len_d   = i_data;
            idx_d   = '0;
`ifdef UART_FRAME_CSUM_EN
            sum_d   = i_data;
`endif
            state_d = ST_PAYLOAD;
          end
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (i_data_vld) begin
          tmo_load = 1'b1;
          buf_we   = 1'b1;
          idx_d    = idx_q + 8'd1;
`ifdef UART_FRAME_CSUM_EN
          sum_d    = sum_chk;
`endif
          if (last_idx) begin
            // Index restarts here so the replay starts at byte 0.
            idx_d   = '0;
`ifdef UART_FRAME_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_OUT;
`endif
          end
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
`ifdef UART_FRAME_CSUM_EN
      ST_CSUM: begin
        if (i_data_vld) begin
          tmo_load = 1'b1;
          if (sum_chk == 8'd0) begin
            state_d = ST_OUT;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = ST_IDLE;
          end
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_OUT: begin
        if (i_data_vld) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (i_rdy) begin
          idx_d = idx_q + 8'd1;
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
`ifdef UART_FRAME_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef UART_FRAME_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Payload store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[IDX_W-1:0]] <= i_data;
    end
  end

  assign o_vld      = (state_q == ST_OUT);
  assign o_data     = o_vld ? buf_q[idx_q[IDX_W-1:0]] : 8'd0;
  assign o_last     = o_vld && last_idx;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames, error causes, stall/overrun, reset, and random frames.
// Expected output comes from frame-level arithmetic on each generated frame.
// Works with or without UART_FRAME_CSUM_EN defined.
module tb_uart_frame_rx;

  localparam int FREQ         = 50_000_000;
  localparam int RATE         = 2_000_000;
  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_BITS = 20;
  localparam int BIT          = FREQ / RATE;
`ifdef UART_FRAME_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       i_data_vld = 1'b0;
  logic [7:0] o_data;
  logic       o_vld, o_last, o_err, o_busy;
  logic [1:0] o_err_code;
  logic       i_rdy = 1'b1;

  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b1;

  int errors = 0;
  int checks = 0;

  uart_frame_rx #(
    .FREQ(FREQ), .RATE(RATE), .MAX_LEN(MAX_LEN), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_data(o_data), .o_vld(o_vld), .o_last(o_last), .i_rdy(i_rdy),
    .o_err(o_err), .o_err_code(o_err_code), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Downstream ready: fixed level or random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Observation: handshakes, error pulses, stall stability.
  int         cyc = 0;
  int         last_strobe = 0;
  int         hold_viol = 0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_out = '0;
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic [1:0] errs[$];

  always @(negedge clk) begin
    cyc++;
    if (i_data_vld) last_strobe = cyc;
    if (prev_stall && ({o_vld, o_last, o_data} !== prev_out)) hold_viol++;
    prev_stall = o_vld && !i_rdy && rst_n;
    prev_out   = {o_vld, o_last, o_data};
    if (o_vld && i_rdy) begin
      got_q.push_back({o_last, o_data});
      got_cyc.push_back(cyc);
    end
    if (o_err) errs.push_back(o_err_code);
  end

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    errs.delete();
    hold_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    i_data = b;
    i_data_vld = 1'b1;
    @(posedge clk);
    #1;
    i_data_vld = 1'b0;
    i_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
  endtask

  // Reference model: a good frame is SYNC, LEN, payload and, with checksum,
  // the byte that makes LEN + payload + csum == 0 mod 256. Delivered output is
  // the payload with the last flag on the final byte.
  task automatic make_frame(input logic [7:0] pl[$], output logic [7:0] fr[$],
                            output logic [8:0] exp[$]);
    logic [7:0] sum;
    fr.delete();
    exp.delete();
    sum = 8'(pl.size());
    fr.push_back(8'hA5);
    fr.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      fr.push_back(pl[i]);
      sum = sum + pl[i];
      exp.push_back({(i == pl.size() - 1), pl[i]});
    end
    if (CSUM_EN) fr.push_back(8'd0 - sum);
  endtask

  function automatic bit same_q(input logic [8:0] a[$], input logic [8:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({o_busy, o_vld, o_last, o_err, o_err_code} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy/vld/last/err/code=%b required 000000",
               {o_busy, o_vld, o_last, o_err, o_err_code});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b err=%b required 0 0", o_busy, o_err);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pl[$], fr[$];
    logic [8:0] exp[$];
    bit ok;
    clear_obs();
    pl = '{8'h11, 8'h22, 8'h33};
    make_frame(pl, fr, exp);
    send_bytes(fr, 0);
    wait_idle(ok);
    checks++;
    if (!ok || !same_q(got_q, exp)) begin
      errors++;
      $display("FAIL basic_data: got %p required %p idle=%0d", got_q, exp, ok);
    end
    checks++;
    if (errs.size() != 0) begin
      errors++;
      $display("FAIL basic_noerr: got %0d error pulses required 0", errs.size());
    end
    checks++;
    if (got_cyc.size() != 3 || got_cyc[0] != last_strobe + 1 || got_cyc[2] != got_cyc[0] + 2) begin
      errors++;
      $display("FAIL basic_timing: handshake cycles %p last byte cycle %0d required %0d,%0d,%0d",
               got_cyc, last_strobe, last_strobe + 1, last_strobe + 2, last_strobe + 3);
    end
  endtask

  task automatic test_csum_err();
    logic [7:0] fr[$];
    bit ok;
    clear_obs();
    fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_bytes(fr, 1);
    wait_idle(ok);
    checks++;
    if (!ok || errs.size() != 1 || errs[0] !== 2'd1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL csum_err: errs %p outputs %0d idle=%0d required errs '{1} outputs 0",
               errs, got_q.size(), ok);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] fr[$];
    bit ok;
    clear_obs();
    fr = '{8'hA5, 8'h00};
    send_bytes(fr, 0);
    wait_idle(ok);
    checks++;
    if (!ok || errs.size() != 1 || errs[0] !== 2'd0) begin
      errors++;
      $display("FAIL len_zero: errs %p idle=%0d required '{0}", errs, ok);
    end
    clear_obs();
    fr = '{8'h3C, 8'hA5, 8'(MAX_LEN + 1)};
    send_bytes(fr, 0);
    wait_idle(ok);
    checks++;
    if (!ok || errs.size() != 1 || errs[0] !== 2'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL len_over: errs %p busy=%b required '{0} busy 0", errs, o_busy);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] pl[$], fr[$];
    logic [8:0] exp[$];
    bit ok;
    clear_obs();
    fr = '{8'hA5, 8'h02, 8'h10};
    send_bytes(fr, 0);
    repeat (19 * BIT) @(negedge clk);
    checks++;
    if (errs.size() != 0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: errs %p busy=%b required none busy 1", errs, o_busy);
    end
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (errs.size() != 1 || errs[0] !== 2'd2 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: errs %p busy=%b required '{2} busy 0", errs, o_busy);
    end
    checks++;
    if (o_err_code !== 2'd2 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL code_hold: code=%0d err=%b required 2 0", o_err_code, o_err);
    end
    clear_obs();
    pl = '{8'h5A, 8'hA5, 8'h01};
    make_frame(pl, fr, exp);
    send_bytes(fr, 2);
    wait_idle(ok);
    checks++;
    if (!ok || !same_q(got_q, exp) || errs.size() != 0) begin
      errors++;
      $display("FAIL after_timeout: got %p errs %p required %p no errs", got_q, errs, exp);
    end
  endtask

  task automatic test_stall_overrun();
    logic [7:0] pl[$], fr[$];
    logic [8:0] exp[$];
    bit ok;
    clear_obs();
    rdy_force = 1'b0;
    @(posedge clk);
    pl = '{8'hC3, 8'h7E};
    make_frame(pl, fr, exp);
    send_bytes(fr, 0);
    repeat (2) @(posedge clk);
    send_byte(8'h99, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (o_vld !== 1'b1 || o_data !== 8'hC3 || o_last !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL stall_present: vld=%b data=%h last=%b taken=%0d required 1 c3 0 0",
               o_vld, o_data, o_last, got_q.size());
    end
    checks++;
    if (errs.size() != 1 || errs[0] !== 2'd3) begin
      errors++;
      $display("FAIL overrun_err: errs %p required '{3}", errs);
    end
    rdy_force = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || !same_q(got_q, exp)) begin
      errors++;
      $display("FAIL stall_data: got %p required %p idle=%0d", got_q, exp, ok);
    end
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable stalled cycles required 0", hold_viol);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pl[$], fr[$];
    logic [8:0] exp[$];
    bit ok;
    clear_obs();
    fr = '{8'hA5, 8'h03, 8'h11};
    send_bytes(fr, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    checks++;
    if (o_busy !== 1'b0 || o_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b vld=%b required 0 0", o_busy, o_vld);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (errs.size() != 0 || o_err_code !== 2'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: errs %p code=%0d busy=%b required none 0 0",
               errs, o_err_code, o_busy);
    end
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    make_frame(pl, fr, exp);
    send_bytes(fr, 1);
    wait_idle(ok);
    checks++;
    if (!ok || !same_q(got_q, exp) || errs.size() != 0) begin
      errors++;
      $display("FAIL after_reset: got %p errs %p required %p", got_q, errs, exp);
    end
  endtask

  task automatic test_random();
    logic [7:0] pl[$], fr[$];
    logic [8:0] exp[$];
    logic [1:0] exp_err[$];
    int         kind, len, ng;
    logic [7:0] g;
    bit         ok;
    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      clear_obs();
      pl.delete();
      exp_err.delete();
      kind = $urandom_range(0, 9);
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 0);
      end
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        fr = '{8'hA5, 8'(len)};
        exp.delete();
        exp_err.push_back(2'd0);
      end else begin
        len = (kind == 2) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        for (int i = 0; i < len; i++) pl.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
        make_frame(pl, fr, exp);
        if (CSUM_EN && kind == 1) begin
          fr[fr.size() - 1] = fr[fr.size() - 1] + 8'($urandom_range(1, 255));
          exp.delete();
          exp_err.push_back(2'd1);
        end
      end
      send_bytes(fr, 3);
      wait_idle(ok);
      checks++;
      if (!ok || !same_q(got_q, exp)) begin
        errors++;
        $display("FAIL rand_data[%0d]: len=%0d got %p required %p", f, len, got_q, exp);
      end
      checks++;
      if (errs.size() != exp_err.size() || (errs.size() == 1 && errs[0] !== exp_err[0])) begin
        errors++;
        $display("FAIL rand_err[%0d]: errs %p required %p", f, errs, exp_err);
      end
      checks++;
      if (hold_viol != 0) begin
        errors++;
        $display("FAIL rand_hold[%0d]: %0d unstable stalled cycles required 0", f, hold_viol);
      end
    end
    rdy_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    if (CSUM_EN) test_csum_err();
    test_bad_len();
    test_timeout();
    test_stall_overrun();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
